// File: rtl/tone_meter.sv
// tone_meter: measures the half-period of an incoming square-wave tone in clk cycles,
// locking once successive full periods agree within tolerance.
module tone_meter #(
  parameter int WIDTH      = 17,
  parameter int TOL        = 4,
  parameter int STABLE     = 3,
  parameter int MIN_PERIOD = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone,
  output logic [WIDTH-1:0] div,
  output logic             valid,
  output logic             silent,
  output logic             note_strobe
);
  localparam int CW = WIDTH + 1;
  localparam int MW = $clog2(STABLE + 1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q, rise, timeout, match;
  logic [CW-1:0] cnt_q, cnt_d, ref_q, ref_d, per, diff;
  logic have_ref_q, have_ref_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic valid_q, silent_q, strobe_q;
  assign rise    = s2_q & ~s3_q;
  assign per     = cnt_q + 1'b1;
  assign timeout = cnt_q == CW'(TIMEOUT);
  assign diff    = per > ref_q ? per - ref_q : ref_q - per;
  assign match   = per >= CW'(MIN_PERIOD) && diff <= CW'(TOL);
  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    have_ref_d = have_ref_q;
    mcnt_d     = mcnt_q;
    div_d      = div_q;
    cnt_d      = rise ? '0 : timeout ? cnt_q : cnt_q + 1'b1;
    if (rise) begin
      case (state_q)
        IDLE: begin
          state_d    = ACQUIRE;
          have_ref_d = 1'b0;
          mcnt_d     = '0;
        end
        ACQUIRE: begin
          ref_d      = per;
          have_ref_d = 1'b1;
          mcnt_d     = (have_ref_q && match) ? mcnt_q + 1'b1 : '0;
          if (mcnt_d == MW'(STABLE)) begin
            state_d = LOCKED;
            div_d   = WIDTH'((per + 1'b1) >> 1);
          end
        end
        default: if (!match) begin
          // lock is held without drift tracking; any outlier restarts acquisition
          state_d    = ACQUIRE;
          ref_d      = per;
          have_ref_d = 1'b1;
          mcnt_d     = '0;
          div_d      = '0;
        end
      endcase
    end else if (timeout && state_q != IDLE) begin
      state_d = IDLE;
      div_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      ref_q      <= '0;
      have_ref_q <= 1'b0;
      mcnt_q     <= '0;
      div_q      <= '0;
      valid_q    <= 1'b0;
      silent_q   <= 1'b1;
      strobe_q   <= 1'b0;
    end else begin
      s1_q       <= tone;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_q      <= ref_d;
      have_ref_q <= have_ref_d;
      mcnt_q     <= mcnt_d;
      div_q      <= div_d;
      valid_q    <= state_d == LOCKED;
      silent_q   <= state_d == IDLE;
      strobe_q   <= state_d == LOCKED && state_q != LOCKED;
    end
  end
  assign div         = div_q;
  assign valid       = valid_q;
  assign silent      = silent_q;
  assign note_strobe = strobe_q;
endmodule

// File: tb/tb_tone_meter.sv
// tb_tone_meter: drives square-wave tones and compares against a period-level model
// that decides lock from a history of measured periods.
module tb_tone_meter;
  localparam int W = 17, TOL = 4, STABLE = 3, MINP = 8, TO = 2500;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;
  logic clk = 0, rst_n = 0, tone = 0;
  logic [W-1:0] div;
  logic valid, silent, note_strobe;
  tone_meter #(.WIDTH(W), .TOL(TOL), .STABLE(STABLE), .MIN_PERIOD(MINP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tone(tone), .div(div), .valid(valid), .silent(silent),
    .note_strobe(note_strobe));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, t = 0, last_rise = 0;
  int strobes = 0, sil_cyc = 0, dbl = 0;
  logic prev_strobe = 0;
  always @(negedge clk) begin
    strobes     <= strobes + (note_strobe ? 1 : 0);
    sil_cyc     <= sil_cyc + (silent ? 1 : 0);
    dbl         <= dbl + ((note_strobe && prev_strobe) ? 1 : 0);
    prev_strobe <= note_strobe;
  end
  int m_state = M_IDLE, m_div = 0, exp_strobes = 0;
  int hist[$];
  function automatic bit near(int p, int r);
    return p >= MINP && (p > r ? p - r : r - p) <= TOL;
  endfunction
  function automatic bit stable_run();
    int n = hist.size();
    if (n < STABLE + 1) return 0;
    for (int k = 1; k <= STABLE; k++) if (!near(hist[n-k], hist[n-k-1])) return 0;
    return 1;
  endfunction
  task automatic model_edge(input int gap);
    if (m_state != M_IDLE && gap > TO + 1) begin m_state = M_IDLE; m_div = 0; end
    if (m_state == M_IDLE) begin
      m_state = M_ACQ;
      hist.delete();
    end else if (m_state == M_ACQ) begin
      hist.push_back(gap);
      if (stable_run()) begin m_state = M_LOCK; m_div = (gap + 1) / 2; exp_strobes++; end
    end else if (!near(gap, hist[hist.size()-1])) begin
      m_state = M_ACQ;
      hist.delete();
      hist.push_back(gap);
      m_div = 0;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    t++;
  endtask
  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi + lo; i++) begin
      tick();
      tone = (i < hi);
      if (i == 0) begin model_edge(t - last_rise); last_rise = t; end
    end
  endtask
  task automatic do_reset();
    tick();
    rst_n = 0;
    tone = 0;
    repeat (3) tick();
    rst_n = 1;
    m_state = M_IDLE;
    m_div = 0;
    hist.delete();
  endtask
  task automatic test_reset();
    int s0, st0, bad;
    tick();
    tests++; if (div !== 0 || valid !== 0 || silent !== 1 || note_strobe !== 0) begin fails++;
      $display("FAIL reset_outputs div=%0d valid=%b silent=%b strobe=%b exp 0/0/1/0", div, valid, silent, note_strobe); end
    rst_n = 1;
    s0 = sil_cyc; st0 = strobes; bad = 0;
    repeat (TO + 500) begin tick(); if (valid !== 0 || div !== 0) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL quiet_outputs bad_cycles=%0d exp 0", bad); end
    tests++; if (sil_cyc - s0 !== TO + 500) begin fails++; $display("FAIL quiet_silent got %0d exp %0d", sil_cyc - s0, TO + 500); end
    tests++; if (strobes !== st0) begin fails++; $display("FAIL quiet_strobe got %0d exp %0d", strobes, st0); end
  endtask
  task automatic test_steady();
    int st0;
    do_reset();
    st0 = strobes;
    for (int k = 0; k < 10; k++) begin
      pulse(1000, 1000);
      tests++; if (valid !== (k >= 4) || div !== (k >= 4 ? W'(1000) : W'(0))) begin fails++;
        $display("FAIL steady_lock k=%0d valid=%b div=%0d exp %b/%0d", k, valid, div, k >= 4, k >= 4 ? 1000 : 0); end
      tests++; if (strobes - st0 !== (k >= 4 ? 1 : 0)) begin fails++;
        $display("FAIL steady_strobe k=%0d got %0d exp %0d", k, strobes - st0, k >= 4 ? 1 : 0); end
    end
  endtask
  task automatic test_tone_change();
    int st0 = strobes;
    for (int k = 0; k < 5; k++) begin
      pulse(800, 800);
      tests++; if (valid !== (m_state == M_LOCK) || div !== W'(m_div)) begin fails++;
        $display("FAIL change_model k=%0d valid=%b div=%0d exp %b/%0d", k, valid, div, m_state == M_LOCK, m_div); end
      if (k == 1) begin
        tests++; if (valid !== 0 || div !== 0) begin fails++; $display("FAIL change_drop valid=%b div=%0d exp 0/0", valid, div); end
      end
    end
    tests++; if (div !== 800 || valid !== 1) begin fails++; $display("FAIL change_relock div=%0d valid=%b exp 800/1", div, valid); end
    tests++; if (strobes - st0 !== 1) begin fails++; $display("FAIL change_strobe got %0d exp 1", strobes - st0); end
  endtask
  task automatic test_jitter();
    int st0;
    do_reset();
    for (int k = 0; k < 6; k++) pulse(1000, (k % 2) ? 1003 : 1000);
    tests++; if (valid !== 1 || div !== W'(m_div) || (div !== 1000 && div !== 1002)) begin fails++;
      $display("FAIL jitter3 valid=%b div=%0d exp 1/%0d", valid, div, m_div); end
    do_reset();
    st0 = strobes;
    for (int k = 0; k < 6; k++) begin
      pulse(1000, (k % 2) ? 1006 : 1000);
      tests++; if (valid !== 0 || div !== 0) begin fails++; $display("FAIL jitter6 k=%0d valid=%b div=%0d exp 0/0", k, valid, div); end
    end
    tests++; if (strobes !== st0) begin fails++; $display("FAIL jitter6_strobe got %0d exp %0d", strobes, st0); end
  endtask
  task automatic test_silence();
    int st0;
    do_reset();
    repeat (5) pulse(200, 200);
    st0 = strobes;
    while (t < last_rise + TO - 5) tick();
    tests++; if (silent !== 0 || valid !== 1 || div !== 200) begin fails++;
      $display("FAIL silence_early silent=%b valid=%b div=%0d exp 0/1/200", silent, valid, div); end
    while (t < last_rise + TO + 10) tick();
    tests++; if (silent !== 1 || valid !== 0 || div !== 0) begin fails++;
      $display("FAIL silence_late silent=%b valid=%b div=%0d exp 1/0/0", silent, valid, div); end
    tests++; if (strobes !== st0) begin fails++; $display("FAIL silence_strobe got %0d exp %0d", strobes, st0); end
    m_state = M_IDLE;
    m_div = 0;
  endtask
  task automatic test_runt();
    int st0;
    do_reset();
    repeat (5) pulse(300, 300);
    tests++; if (valid !== 1 || div !== 300) begin fails++; $display("FAIL runt_prelock valid=%b div=%0d exp 1/300", valid, div); end
    pulse(300, 100);
    pulse(3, 197);
    tests++; if (valid !== 0 || div !== 0 || valid !== (m_state == M_LOCK)) begin fails++;
      $display("FAIL runt_drop valid=%b div=%0d exp 0/0", valid, div); end
    st0 = strobes;
    repeat (5) pulse(300, 300);
    tests++; if (valid !== 1 || div !== 300 || strobes - st0 !== 1) begin fails++;
      $display("FAIL runt_relock valid=%b div=%0d strobes=%0d exp 1/300/1", valid, div, strobes - st0); end
  endtask
  task automatic test_async_reset();
    do_reset();
    repeat (3) pulse(400, 400);
    tick();
    tests++; if (silent !== 0) begin fails++; $display("FAIL areset_pre silent=%b exp 0", silent); end
    rst_n = 0;
    #1;
    tests++; if (silent !== 1 || valid !== 0 || div !== 0 || note_strobe !== 0) begin fails++;
      $display("FAIL areset_now silent=%b valid=%b div=%0d strobe=%b exp 1/0/0/0", silent, valid, div, note_strobe); end
    repeat (3) tick();
    rst_n = 1;
    m_state = M_IDLE; m_div = 0; hist.delete();
    for (int k = 0; k < 5; k++) begin
      pulse(400, 400);
      tests++; if (valid !== (k == 4) || div !== (k == 4 ? W'(400) : W'(0)) || valid !== (m_state == M_LOCK)) begin fails++;
        $display("FAIL areset_relock k=%0d valid=%b div=%0d exp %b/%0d", k, valid, div, k == 4, k == 4 ? 400 : 0); end
    end
  endtask
  task automatic test_timeout_edge();
    int s0;
    do_reset();
    pulse(50, 50);
    pulse(50, 50);
    pulse(50, TO + 1 - 50);
    s0 = sil_cyc;
    pulse(50, 50);
    tests++; if (sil_cyc !== s0 || silent !== 0) begin fails++;
      $display("FAIL edge_wins silent_cycles=%0d exp 0", sil_cyc - s0); end
    pulse(50, TO + 2 - 50);
    s0 = sil_cyc;
    pulse(50, 50);
    tests++; if (sil_cyc - s0 < 1 || silent !== 0) begin fails++;
      $display("FAIL timeout_first silent_cycles=%0d exp >=1", sil_cyc - s0); end
    repeat (4) pulse(50, 50);
    tests++; if (valid !== (m_state == M_LOCK) || div !== W'(m_div) || strobes !== exp_strobes) begin fails++;
      $display("FAIL timeout_relock valid=%b div=%0d strobes=%0d exp %b/%0d/%0d", valid, div, strobes, m_state == M_LOCK, m_div, exp_strobes); end
  endtask
  task automatic test_random();
    int base = 3;
    do_reset();
    exp_strobes = strobes;
    for (int k = 0; k < 48; k++) begin
      if (k % 8 == 0) base = (k % 16 == 0) ? $urandom_range(3, 6) : $urandom_range(7, 150);
      pulse(base, base + $urandom_range(0, 6));
      tests++; if (valid !== (m_state == M_LOCK) || div !== W'(m_div) || silent !== 0) begin fails++;
        $display("FAIL random k=%0d valid=%b div=%0d silent=%b exp %b/%0d/0", k, valid, div, silent, m_state == M_LOCK, m_div); end
      tests++; if (strobes !== exp_strobes) begin fails++;
        $display("FAIL random_strobe k=%0d got %0d exp %0d", k, strobes, exp_strobes); end
    end
  endtask
  initial begin
    test_reset();
    test_steady();
    test_tone_change();
    test_jitter();
    test_silence();
    test_runt();
    test_async_reset();
    test_timeout_edge();
    test_random();
    tick();
    tests++; if (dbl !== 0) begin fails++; $display("FAIL strobe_double got %0d exp 0", dbl); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
